// File: rtl/clk_en_sequencer.sv
// Staggered power-up / reverse power-down sequencer for a bank of clock generator enables.
// gen_en is kept as a thermometer code whose top set bit is always gen_en[idx] while busy.
module clk_en_sequencer #(
    parameter int NUM_GEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W-1:0]   gap,
    input  logic [CNT_W-1:0]   settle,
    output logic [NUM_GEN-1:0] gen_en,
    output logic               busy,
    output logic               ready,
    output logic               done
);

    localparam int IDX_W = (NUM_GEN > 1) ? $clog2(NUM_GEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        UP,
        SETTLE,
        RUN,
        DOWN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] gap_q;
    logic [CNT_W-1:0] settle_q;

    logic [IDX_W-1:0] idx_inc;
    logic [IDX_W-1:0] idx_dec;
    logic             abort_req;

    assign idx_inc   = idx + IDX_W'(1);
    assign idx_dec   = idx - IDX_W'(1);
    assign abort_req = stop && ((state == UP) || (state == SETTLE) || (state == RUN));

    // A stop in UP/SETTLE/RUN drops the top enable on that same edge, so RUN's stop is just an abort from a full bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            gap_q    <= '0;
            settle_q <= '0;
            gen_en   <= '0;
            busy     <= 1'b0;
            ready    <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort_req) begin
                gen_en[idx] <= 1'b0;
                ready       <= 1'b0;
                if (idx == '0) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    cnt   <= '0;
                end else begin
                    state <= DOWN;
                    idx   <= idx_dec;
                    cnt   <= gap_q;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            gap_q    <= gap;
                            settle_q <= settle;
                            gen_en   <= NUM_GEN'(1);
                            idx      <= '0;
                            cnt      <= gap;
                            busy     <= 1'b1;
                            state    <= UP;
                        end
                    end
                    // Turning on the last generator starts the settle wait on the same edge.
                    UP: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else begin
                            idx             <= idx_inc;
                            gen_en[idx_inc] <= 1'b1;
                            if (idx_inc == LAST_IDX) begin
                                cnt   <= settle_q;
                                state <= SETTLE;
                            end else begin
                                cnt <= gap_q;
                            end
                        end
                    end
                    SETTLE: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else begin
                            ready <= 1'b1;
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        state <= RUN;
                    end
                    DOWN: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else begin
                            gen_en[idx] <= 1'b0;
                            if (idx == '0) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                idx <= idx_dec;
                                cnt <= gap_q;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
